// File: rtl/sid_filter_sequencer.sv
// Sequences the shared SID filter through its pipeline stages for each enabled SID
// and captures the resulting audio sample one cycle after the final stage.
module sid_filter_sequencer #(
    parameter int AUDIO_W    = 20,
    parameter int LAST_STAGE = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [1:0]                en_i,
    input  logic                      clr_ovr_i,
    input  logic signed [AUDIO_W-1:0] audio_i,
    output logic [2:0]                stage_o,
    output logic                      sidno_o,
    output logic signed [AUDIO_W-1:0] audio0_o,
    output logic signed [AUDIO_W-1:0] audio1_o,
    output logic [1:0]                valid_o,
    output logic                      busy_o,
    output logic                      overrun_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] LAST_S = 3'(LAST_STAGE);

    state_t                     state_r, state_s;
    logic [2:0]                 stage_r, stage_s;
    logic                       sidno_r, sidno_s;
    logic                       more_r, more_s;
    logic                       pend_valid_r, pend_valid_s;
    logic                       pend_id_r, pend_id_s;
    logic [1:0]                 valid_r, valid_s;
    logic                       busy_r, busy_s;
    logic                       overrun_r, overrun_s;
    logic signed [AUDIO_W-1:0]  audio0_r, audio1_r;
    logic                       accept_s, reject_s;

    // Next-state, stage sequencing, capture scheduling and status flags.
    always_comb begin
        state_s      = state_r;
        stage_s      = stage_r;
        sidno_s      = sidno_r;
        more_s       = more_r;
        pend_valid_s = 1'b0;
        pend_id_s    = pend_id_r;
        accept_s     = start_i && !busy_r && (en_i != 2'b00);
        reject_s     = start_i && busy_r;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                    stage_s = 3'd1;
                    sidno_s = ~en_i[0];
                    // SID 1 still owed only when SID 0 goes first
                    more_s  = en_i[0] & en_i[1];
                end else begin
                    stage_s = 3'd0;
                end
            end
            RUN: begin
                if (stage_r == LAST_S) begin
                    pend_valid_s = 1'b1;
                    pend_id_s    = sidno_r;
                    if (more_r) begin
                        stage_s = 3'd1;
                        sidno_s = 1'b1;
                        more_s  = 1'b0;
                    end else begin
                        state_s = IDLE;
                        stage_s = 3'd0;
                    end
                end else begin
                    stage_s = stage_r + 3'd1;
                end
            end
            default: begin
                state_s = IDLE;
                stage_s = 3'd0;
                more_s  = 1'b0;
            end
        endcase

        busy_s = (state_s == RUN) || pend_valid_s;

        if (pend_valid_r) begin
            valid_s = pend_id_r ? 2'b10 : 2'b01;
        end else begin
            valid_s = 2'b00;
        end

        // A rejected start wins over a simultaneous clear
        if (reject_s) begin
            overrun_s = 1'b1;
        end else if (clr_ovr_i) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end
    end

    // State, output and audio capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            stage_r      <= 3'd0;
            sidno_r      <= 1'b0;
            more_r       <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_id_r    <= 1'b0;
            valid_r      <= 2'b00;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
            audio0_r     <= '0;
            audio1_r     <= '0;
        end else begin
            state_r      <= state_s;
            stage_r      <= stage_s;
            sidno_r      <= sidno_s;
            more_r       <= more_s;
            pend_valid_r <= pend_valid_s;
            pend_id_r    <= pend_id_s;
            valid_r      <= valid_s;
            busy_r       <= busy_s;
            overrun_r    <= overrun_s;
            if (pend_valid_r && pend_id_r) begin
                audio1_r <= audio_i;
            end else if (pend_valid_r) begin
                audio0_r <= audio_i;
            end else begin
                audio0_r <= audio0_r;
            end
        end
    end

    assign stage_o   = stage_r;
    assign sidno_o   = sidno_r;
    assign audio0_o  = audio0_r;
    assign audio1_o  = audio1_r;
    assign valid_o   = valid_r;
    assign busy_o    = busy_r;
    assign overrun_o = overrun_r;

endmodule

// File: tb/tb_sid_filter_sequencer.sv
// Scoreboard bench for sid_filter_sequencer: a filter model feeds audio_i and
// expected captures are queued at each accepted start.
module tb_sid_filter_sequencer;

    localparam int W = 20;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start_i = 1'b0;
    logic [1:0]          en_i = 2'b00;
    logic                clr_ovr_i = 1'b0;
    logic signed [W-1:0] audio_i;
    logic [2:0]          stage_o;
    logic                sidno_o;
    logic signed [W-1:0] audio0_o;
    logic signed [W-1:0] audio1_o;
    logic [1:0]          valid_o;
    logic                busy_o;
    logic                overrun_o;

    sid_filter_sequencer #(.AUDIO_W(W), .LAST_STAGE(7)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .en_i(en_i),
        .clr_ovr_i(clr_ovr_i), .audio_i(audio_i), .stage_o(stage_o),
        .sidno_o(sidno_o), .audio0_o(audio0_o), .audio1_o(audio1_o),
        .valid_o(valid_o), .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    // Filter model: result for the SID at stage 7 appears on audio_i next cycle
    logic [W-1:0] sid_val [2];
    logic [W-1:0] model_audio = '0;
    always @(posedge clk) if (stage_o == 3'd7) model_audio <= sid_val[sidno_o];
    assign audio_i = model_audio;

    typedef struct {
        logic         sid;
        logic [W-1:0] val;
    } cap_t;
    cap_t sb[$];
    cap_t mon_e;
    logic [W-1:0] mon_got;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard pops an expected capture on every valid pulse
    always @(negedge clk) begin
        if (rst_n && valid_o != 2'b00) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected valid_o=%b, expected no pulse", valid_o);
            end else begin
                mon_e = sb.pop_front();
                if (valid_o !== (mon_e.sid ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL sb_valid got %b exp sid %0d", valid_o, mon_e.sid);
                end
                n_checks++;
                mon_got = mon_e.sid ? audio1_o : audio0_o;
                if (mon_got !== mon_e.val) begin
                    n_fail++;
                    $display("FAIL sb_audio sid %0d got %h exp %h", mon_e.sid, mon_got, mon_e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [1:0] en);
        cap_t e;
        if (en[0]) begin e.sid = 1'b0; e.val = sid_val[0]; sb.push_back(e); end
        if (en[1]) begin e.sid = 1'b1; e.val = sid_val[1]; sb.push_back(e); end
    endtask

    task automatic start_job(input logic [1:0] en);
        start_i = 1'b1;
        en_i    = en;
        push_job(en);
        tick();
        start_i = 1'b0;
    endtask

    // Expected trace, cycle c counted from the accepting edge (c=1 first stage)
    function automatic int njobs(input logic [1:0] en);
        return int'(en[0]) + int'(en[1]);
    endfunction
    function automatic logic job_sid(input logic [1:0] en, input int j);
        return (j == 0) ? ~en[0] : 1'b1;
    endfunction
    function automatic logic [2:0] exp_stage(input logic [1:0] en, input int c);
        if (c >= 1 && c <= 7 * njobs(en)) return 3'((c - 1) % 7 + 1);
        return 3'd0;
    endfunction
    function automatic logic exp_sid(input logic [1:0] en, input int c);
        return job_sid(en, (c - 1) / 7);
    endfunction
    function automatic logic [1:0] exp_valid(input logic [1:0] en, input int c);
        for (int j = 0; j < njobs(en); j++)
            if (c == 9 + 7 * j) return job_sid(en, j) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction
    function automatic logic exp_busy(input logic [1:0] en, input int c);
        return njobs(en) > 0 && c >= 1 && c <= 8 + 7 * (njobs(en) - 1);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b1; en_i = 2'b11;
        tick(); tick();
        n_checks += 7;
        if (stage_o !== 3'd0)     begin n_fail++; $display("FAIL rst_stage got %0d exp 0", stage_o); end
        if (sidno_o !== 1'b0)     begin n_fail++; $display("FAIL rst_sidno got %0d exp 0", sidno_o); end
        if (busy_o !== 1'b0)      begin n_fail++; $display("FAIL rst_busy got %0d exp 0", busy_o); end
        if (valid_o !== 2'b00)    begin n_fail++; $display("FAIL rst_valid got %b exp 00", valid_o); end
        if (overrun_o !== 1'b0)   begin n_fail++; $display("FAIL rst_overrun got %0d exp 0", overrun_o); end
        if (audio0_o !== 20'h0)   begin n_fail++; $display("FAIL rst_audio0 got %h exp 0", audio0_o); end
        if (audio1_o !== 20'h0)   begin n_fail++; $display("FAIL rst_audio1 got %h exp 0", audio1_o); end
        rst_n = 1'b1; start_i = 1'b0; en_i = 2'b00;
        tick();
        n_checks++;
        if (stage_o !== 3'd0) begin n_fail++; $display("FAIL rst_start_ignored stage got %0d exp 0", stage_o); end
    endtask

    task automatic test_two_sid();
        logic [2:0] es;
        sid_val[0] = 20'h12345; sid_val[1] = 20'hFEDCB;
        start_job(2'b11);
        for (int c = 1; c <= 18; c++) begin
            es = exp_stage(2'b11, c);
            n_checks += 3;
            if (stage_o !== es) begin n_fail++; $display("FAIL two_stage c=%0d got %0d exp %0d", c, stage_o, es); end
            if (valid_o !== exp_valid(2'b11, c)) begin n_fail++; $display("FAIL two_valid c=%0d got %b exp %b", c, valid_o, exp_valid(2'b11, c)); end
            if (busy_o !== exp_busy(2'b11, c)) begin n_fail++; $display("FAIL two_busy c=%0d got %0d exp %0d", c, busy_o, exp_busy(2'b11, c)); end
            if (es != 3'd0) begin
                n_checks++;
                if (sidno_o !== exp_sid(2'b11, c)) begin n_fail++; $display("FAIL two_sidno c=%0d got %0d exp %0d", c, sidno_o, exp_sid(2'b11, c)); end
            end
            tick();
        end
        n_checks += 2;
        if (audio0_o !== 20'h12345) begin n_fail++; $display("FAIL two_hold0 got %h exp 12345", audio0_o); end
        if (audio1_o !== 20'hFEDCB) begin n_fail++; $display("FAIL two_hold1 got %h exp fedcb", audio1_o); end
    endtask

    task automatic test_single_sid1();
        sid_val[1] = 20'h0ABCD;
        start_job(2'b10);
        for (int c = 1; c <= 12; c++) begin
            n_checks += 4;
            if (stage_o !== exp_stage(2'b10, c)) begin n_fail++; $display("FAIL one_stage c=%0d got %0d exp %0d", c, stage_o, exp_stage(2'b10, c)); end
            if (valid_o !== exp_valid(2'b10, c)) begin n_fail++; $display("FAIL one_valid c=%0d got %b exp %b", c, valid_o, exp_valid(2'b10, c)); end
            if (busy_o !== exp_busy(2'b10, c)) begin n_fail++; $display("FAIL one_busy c=%0d got %0d exp %0d", c, busy_o, exp_busy(2'b10, c)); end
            if (audio0_o !== 20'h12345) begin n_fail++; $display("FAIL one_audio0 c=%0d got %h exp 12345", c, audio0_o); end
            if (c <= 7) begin
                n_checks++;
                if (sidno_o !== 1'b1) begin n_fail++; $display("FAIL one_sidno c=%0d got %0d exp 1", c, sidno_o); end
            end
            tick();
        end
    endtask

    task automatic test_empty();
        start_job(2'b00);
        for (int c = 1; c <= 4; c++) begin
            n_checks += 4;
            if (stage_o !== 3'd0)   begin n_fail++; $display("FAIL empty_stage c=%0d got %0d exp 0", c, stage_o); end
            if (busy_o !== 1'b0)    begin n_fail++; $display("FAIL empty_busy c=%0d got %0d exp 0", c, busy_o); end
            if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL empty_overrun c=%0d got %0d exp 0", c, overrun_o); end
            if (valid_o !== 2'b00)  begin n_fail++; $display("FAIL empty_valid c=%0d got %b exp 00", c, valid_o); end
            tick();
        end
    endtask

    task automatic test_overrun();
        logic eo;
        sid_val[0] = 20'h00777; sid_val[1] = 20'h80001;
        start_job(2'b11);
        for (int c = 1; c <= 22; c++) begin
            eo = (c >= 6 && c <= 20);
            n_checks += 3;
            if (overrun_o !== eo) begin n_fail++; $display("FAIL ovr_flag c=%0d got %0d exp %0d", c, overrun_o, eo); end
            if (stage_o !== exp_stage(2'b11, c)) begin n_fail++; $display("FAIL ovr_stage c=%0d got %0d exp %0d", c, stage_o, exp_stage(2'b11, c)); end
            if (valid_o !== exp_valid(2'b11, c)) begin n_fail++; $display("FAIL ovr_valid c=%0d got %b exp %b", c, valid_o, exp_valid(2'b11, c)); end
            en_i      = (c >= 3) ? 2'b01 : 2'b11;
            start_i   = (c == 5);
            clr_ovr_i = (c == 20);
            tick();
        end
        start_i = 1'b0; clr_ovr_i = 1'b0;
    endtask

    task automatic test_clr_priority();
        sid_val[0] = 20'h54321;
        start_job(2'b01);
        for (int c = 1; c <= 13; c++) begin
            if (c == 4 || c == 13) begin
                n_checks++;
                if (overrun_o !== (c == 4)) begin n_fail++; $display("FAIL prio_overrun c=%0d got %0d exp %0d", c, overrun_o, c == 4); end
            end
            n_checks++;
            if (busy_o !== exp_busy(2'b01, c)) begin n_fail++; $display("FAIL prio_busy c=%0d got %0d exp %0d", c, busy_o, exp_busy(2'b01, c)); end
            start_i   = (c == 3);
            clr_ovr_i = (c == 3 || c == 12);
            tick();
        end
        start_i = 1'b0; clr_ovr_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        sid_val[0] = 20'h0F0F0; sid_val[1] = 20'h0A0A0;
        start_job(2'b11);
        for (int c = 1; c <= 8; c++) begin
            n_checks++;
            if (stage_o !== exp_stage(2'b11, c)) begin n_fail++; $display("FAIL rmid_stage c=%0d got %0d exp %0d", c, stage_o, exp_stage(2'b11, c)); end
            if (c == 8) begin rst_n = 1'b0; start_i = 1'b1; end
            tick();
        end
        n_checks += 6;
        if (stage_o !== 3'd0)   begin n_fail++; $display("FAIL rmid_stage9 got %0d exp 0", stage_o); end
        if (busy_o !== 1'b0)    begin n_fail++; $display("FAIL rmid_busy9 got %0d exp 0", busy_o); end
        if (valid_o !== 2'b00)  begin n_fail++; $display("FAIL rmid_valid9 got %b exp 00", valid_o); end
        if (audio0_o !== 20'h0) begin n_fail++; $display("FAIL rmid_audio0 got %h exp 0", audio0_o); end
        if (audio1_o !== 20'h0) begin n_fail++; $display("FAIL rmid_audio1 got %h exp 0", audio1_o); end
        if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL rmid_overrun got %0d exp 0", overrun_o); end
        sb.delete();
        rst_n = 1'b1; start_i = 1'b0;
        for (int c = 10; c <= 25; c++) begin
            tick();
            n_checks += 2;
            if (valid_o !== 2'b00) begin n_fail++; $display("FAIL rmid_late_valid c=%0d got %b exp 00", c, valid_o); end
            if (stage_o !== 3'd0)  begin n_fail++; $display("FAIL rmid_late_stage c=%0d got %0d exp 0", c, stage_o); end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        sid_val[0] = 20'h11111; sid_val[1] = 20'h22222;
        start_job(2'b11);
        for (int c = 1; c <= 34; c++) begin
            k = (c >= 17) ? c - 16 : c;
            n_checks += 4;
            if (stage_o !== exp_stage(2'b11, k)) begin n_fail++; $display("FAIL b2b_stage c=%0d got %0d exp %0d", c, stage_o, exp_stage(2'b11, k)); end
            if (valid_o !== exp_valid(2'b11, k)) begin n_fail++; $display("FAIL b2b_valid c=%0d got %b exp %b", c, valid_o, exp_valid(2'b11, k)); end
            if (busy_o !== exp_busy(2'b11, k)) begin n_fail++; $display("FAIL b2b_busy c=%0d got %0d exp %0d", c, busy_o, exp_busy(2'b11, k)); end
            if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun c=%0d got %0d exp 0", c, overrun_o); end
            if (c == 17) begin
                n_checks++;
                if (sidno_o !== 1'b0) begin n_fail++; $display("FAIL b2b_sidno17 got %0d exp 0", sidno_o); end
            end
            start_i = (c == 16);
            if (c == 16) begin
                sid_val[0] = 20'h33333; sid_val[1] = 20'h44444;
                en_i = 2'b11;
                push_job(2'b11);
            end
            tick();
        end
        start_i = 1'b0;
    endtask

    initial begin
        sid_val[0] = '0; sid_val[1] = '0;
        test_reset();
        test_two_sid();
        test_single_sid1();
        test_empty();
        test_overrun();
        test_clr_priority();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover got %0d entries exp 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sid_filter_sequencer.md
SID_FILTER_SEQUENCER -- requirements
Module: sid_filter_sequencer

Interface
REQ-001 SHALL have parameter AUDIO_W, default 20: width of the signed filter audio sample.
REQ-002 SHALL have parameter LAST_STAGE, default 7: final filter pipeline stage number.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port start_i, input, 1: sample tick, one pulse per SID cycle.
REQ-006 SHALL have port en_i, input, 2: per-SID enable, bit n = sidno n; sampled only when a start is accepted.
REQ-007 SHALL have port clr_ovr_i, input, 1: clears the overrun flag.
REQ-008 SHALL have port audio_i, input, AUDIO_W signed: filter audio output.
REQ-009 SHALL have port stage_o, output, 3: stage number driven to the filter; 0 = no operation.
REQ-010 SHALL have port sidno_o, output, 1: SID instance selected for the current stage.
REQ-011 SHALL have port audio0_o, output, AUDIO_W signed: last captured SID 0 sample.
REQ-012 SHALL have port audio1_o, output, AUDIO_W signed: last captured SID 1 sample.
REQ-013 SHALL have port valid_o, output, 2: one-cycle pulse on bit n when audioN_o updates.
REQ-014 SHALL have port busy_o, output, 1: high while a sequence or a pending capture is outstanding.
REQ-015 SHALL have port overrun_o, output, 1: sticky flag, set when a start is rejected.

Function
REQ-016 SHALL implement the FSM states IDLE and RUN, plus an independent one-entry capture-pending register holding a valid bit and a sid id.
REQ-017 Start acceptance: in IDLE with busy_o low, start_i=1 and en_i!=0 SHALL latch en_i as the job mask and enter RUN with stage_o=1 in the next cycle.
REQ-018 sidno_o SHALL select the lowest enabled SID first: SID 0, then SID 1 when both are enabled.
REQ-019 In RUN, stage_o SHALL increment by 1 each cycle from 1 to LAST_STAGE, with no gaps.
REQ-020 After LAST_STAGE, if a further enabled SID remains, the next cycle SHALL present stage_o=1 with the new sidno_o; otherwise the FSM SHALL return to IDLE with stage_o=0.
REQ-021 In any cycle where stage_o==LAST_STAGE, the capture-pending register SHALL be loaded with the current sidno_o on that cycle's edge.
REQ-022 In the following cycle, audio_i SHALL be latched into audio<id>_o at the cycle's end, and valid_o[id] SHALL be high for exactly the next cycle.
REQ-023 The capture SHALL overlap with stage 1 of the next SID; no bubble is inserted.
REQ-024 busy_o SHALL be high from the cycle after acceptance until the final capture completes, going low in the cycle where the last valid_o pulse is visible.
REQ-025 With both SIDs enabled and start sampled in cycle 0:
  - stages run in cycles 1-14;
  - stage_o=0 in cycle 15;
  - valid_o[0] is high in cycle 9 and valid_o[1] in cycle 16;
  - busy_o is high in cycles 1-15.
REQ-026 start_i=1 while busy_o is high SHALL be ignored and SHALL set overrun_o.
REQ-027 start_i=1 with en_i==0 SHALL be accepted as an empty job: no stages run, busy_o stays low, overrun_o is not set.
REQ-028 clr_ovr_i SHALL clear overrun_o on the next edge; if a rejected start occurs in the same cycle, the set SHALL take priority.
REQ-029 Changes on en_i during RUN SHALL have no effect.
REQ-030 audioN_o SHALL hold its value between captures.
REQ-031 valid_o bits SHALL never be high simultaneously.

Reset
REQ-032 rst_n=0 on a rising edge SHALL drive these values in the next cycle:
  - state IDLE, stage_o=0, sidno_o=0;
  - busy_o=0, valid_o=0, overrun_o=0;
  - audio0_o=audio1_o=0;
  - capture-pending cleared.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence and discard any pending capture, with no valid_o pulse afterwards.
REQ-034 start_i during a reset cycle SHALL be ignored.

Verification
REQ-035 Reset, then start with en_i=2'b11 and the filter model returning 20'h12345 for SID 0 and 20'hFEDCB for SID 1 -> stage/sidno trace per REQ-025, audio0_o=20'h12345, audio1_o=20'hFEDCB, valid pulses in cycles 9 and 16.
REQ-036 Start with en_i=2'b10 -> sidno_o=1 for stages 1-7 in cycles 1-7, valid_o=2'b10 in cycle 9, busy_o low from cycle 9, audio0_o unchanged.
REQ-037 Start accepted at cycle 0 (en_i=2'b11), second start at cycle 5 -> second start ignored, overrun_o=1 from cycle 6 and held; clr_ovr_i in cycle 20 -> overrun_o=0 in cycle 21.
REQ-038 clr_ovr_i together with a rejected start in the same cycle -> overrun_o remains 1.
REQ-039 rst_n=0 in cycle 8 of a two-SID job -> cycle 9 shows stage_o=0, busy_o=0, valid_o=0, audio0_o=0; no later valid pulse.
REQ-040 Back-to-back starts in cycles 0 and 16 with en_i=2'b11 -> both accepted, second job stage 1 in cycle 17, no overrun.
